// File: rtl/de2_115_switch_pkg.sv
// Shared definitions for the DE2-115 slide-switch scan controller:
// register addresses, sequencing FSM states and debounce counter sizing.
package de2_115_switch_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RAW     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

    function automatic int cnt_width(input int stable_cnt);
        return $clog2(stable_cnt + 1);
    endfunction

endpackage

// File: rtl/de2_115_switch_scan_ctrl_debounce_cell.sv
// One switch bit: 2-flop synchroniser, tick-counted debounce and the
// single-cycle edge pulse raised whenever the debounced value changes.
module switch_debounce_cell
    import de2_115_switch_pkg::*;
#(
    parameter int STABLE_CNT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    input  logic prime,
    input  logic run,
    input  logic tick,
    output logic sync,
    output logic stable,
    output logic edge_pulse
);

    localparam int CNT_W = cnt_width(STABLE_CNT);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d   = stable_q;
        cnt_d      = '0;
        edge_pulse = 1'b0;
        if (prime) begin
            // Power-up positions are adopted silently.
            stable_d = sync_q;
        end else if (run && (sync_q != stable_q)) begin
            cnt_d = cnt_q;
            if (tick) begin
                if (cnt_q == CNT_W'(STABLE_CNT - 1)) begin
                    stable_d   = sync_q;
                    cnt_d      = '0;
                    edge_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= pin;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sync   = sync_q;
    assign stable = stable_q;

endmodule

// File: rtl/de2_115_switch_scan_ctrl.sv
// DE2-115 slide-switch controller: debounced DATA, RAW, EDGECAP (W1C) and
// IRQMASK over Avalon-MM. Optional macro SWITCH_IRQ_EN enables IRQMASK and irq.
module de2_115_switch_scan_ctrl
    import de2_115_switch_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int PW = $clog2(TICK_DIV);

    state_e           state_q, state_d;
    logic             fill_q, fill_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             run, prime, tick;
    logic             wr_en, rd_en;
    logic [WIDTH-1:0] sync_w, stable_w, edge_w, w1c;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             unused_wdata;

    assign run   = (state_q == RUN);
    assign prime = (state_q == PRIME);
    assign tick  = run && (presc_q == PW'(TICK_DIV - 1));
    assign unused_wdata = ^writedata[31:WIDTH];

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        unique case (state_q)
            FILL: begin
                // Two cycles let the synchroniser settle before priming.
                if (fill_q) begin
                    state_d = PRIME;
                    fill_d  = 1'b0;
                end else begin
                    fill_d = 1'b1;
                end
            end
            PRIME:   state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        presc_d = '0;
        if (run && !tick) begin
            presc_d = presc_q + PW'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        switch_debounce_cell #(
            .STABLE_CNT(STABLE_CNT)
        ) u_cell (
            .clk       (clk),
            .reset     (reset),
            .pin       (in_port[i]),
            .prime     (prime),
            .run       (run),
            .tick      (tick),
            .sync      (sync_w[i]),
            .stable    (stable_w[i]),
            .edge_pulse(edge_w[i])
        );
    end

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & write_n;
    assign w1c   = (wr_en && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        // A fresh edge overrides a coincident clear.
        edge_cap_d = (edge_cap_q & ~w1c) | edge_w;
`ifdef SWITCH_IRQ_EN
        irq_mask_d = (wr_en && (address == ADDR_IRQMASK)) ? writedata[WIDTH-1:0] : irq_mask_q;
        irq_d      = |(edge_cap_q & irq_mask_q);
`else
        irq_mask_d = '0;
        irq_d      = 1'b0;
`endif
    end

    always_comb begin
        readdata_d = '0;
        if (rd_en) begin
            unique case (address)
                ADDR_DATA:    readdata_d = 32'(stable_w);
                ADDR_RAW:     readdata_d = 32'(sync_w);
                ADDR_IRQMASK: readdata_d = 32'(irq_mask_q);
                ADDR_EDGECAP: readdata_d = 32'(edge_cap_q);
                default:      readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            fill_q     <= 1'b0;
            presc_q    <= '0;
            edge_cap_q <= '0;
            irq_mask_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            presc_q    <= presc_d;
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_de2_115_switch_scan_ctrl.sv
// Bench for de2_115_switch_scan_ctrl: directed scenarios with literal
// expectations plus randomized pins/bus checked against a behavioural model.
module tb_de2_115_switch_scan_ctrl;

    localparam int W  = 18;
    localparam int TD = 4;
    localparam int SC = 3;
`ifdef SWITCH_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_port;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          irq;

    int checks   = 0;
    int failures = 0;

    de2_115_switch_scan_ctrl #(
        .WIDTH(W), .TICK_DIV(TD), .STABLE_CNT(SC)
    ) dut (
        .clk(clk), .reset(reset), .in_port(in_port), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: sync is the pin two edges late; a bit is accepted once
    // it has differed continuously over an interval containing SC ticks.
    logic [W-1:0] m_meta, m_sync, m_stable, m_edge, m_mask, n_stable, n_edge, clr;
    logic [31:0]  m_rd, rv;
    logic         m_irq, n_irq;
    int           since_rst = 0;
    int           m_start[W];
    int           r;
    bit           m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_meta = '0; m_sync = '0; m_stable = '0; m_edge = '0; m_mask = '0;
            m_rd = '0; m_irq = 1'b0; since_rst = 0; m_valid = 1'b1;
            for (int i = 0; i < W; i++) m_start[i] = -1;
        end else begin
            n_stable = m_stable;
            n_edge   = '0;
            if (since_rst == 2) begin
                n_stable = m_sync;
            end else if (since_rst >= 3) begin
                r = since_rst - 3;
                for (int i = 0; i < W; i++) begin
                    if (m_sync[i] == m_stable[i]) begin
                        m_start[i] = -1;
                    end else begin
                        if (m_start[i] < 0) m_start[i] = r;
                        if ((r + 1) / TD - m_start[i] / TD >= SC) begin
                            n_stable[i] = m_sync[i];
                            n_edge[i]   = 1'b1;
                            m_start[i]  = -1;
                        end
                    end
                end
            end
            case (address)
                2'd0:    rv = 32'(m_stable);
                2'd1:    rv = 32'(m_sync);
                2'd2:    rv = 32'(m_mask);
                default: rv = 32'(m_edge);
            endcase
            m_rd  = (chipselect && write_n) ? rv : 32'd0;
            n_irq = IRQ_EN && ((m_edge & m_mask) != '0);
            clr   = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            if (IRQ_EN && chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
            m_edge   = (m_edge & ~clr) | n_edge;
            m_irq    = n_irq;
            m_stable = n_stable;
            m_sync   = m_meta;
            m_meta   = in_port;
            since_rst++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (readdata !== m_rd) begin
                failures++;
                if (failures < 20) $display("FAIL model_readdata t=%0t got 0x%08h expected 0x%08h", $time, readdata, m_rd);
            end
            checks++;
            if (irq !== m_irq) begin
                failures++;
                if (failures < 20) $display("FAIL model_irq t=%0t got %0b expected %0b", $time, irq, m_irq);
            end
        end
    end

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0;
        check32(nm, readdata, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    // Waits until bit b starts mismatching, then until the edge with run index
    // that has seen k ticks of the mismatch is the next one (k<SC) or has passed.
    task automatic wait_ticks(input int b, input int k, input bit after, input string nm);
        int g, tgt;
        g = 0;
        while (m_start[b] < 0 && g < 40) begin @(posedge clk); #1; g++; end
        tgt = m_start[b];
        while ((tgt + 1) / TD - m_start[b] / TD < k) tgt++;
        if (after) tgt++;
        g = 0;
        while ((since_rst - 3) != tgt && g < 60) begin @(posedge clk); #1; g++; end
        checks++;
        if ((since_rst - 3) != tgt) begin
            failures++;
            $display("FAIL %s_align got %0d expected %0d", nm, since_rst - 3, tgt);
        end
    endtask

    initial begin
        reset = 1'b1; in_port = 18'h00005; address = 2'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check32("reset_readdata", readdata, 32'h0);
        check32("reset_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        idle(4);
        bus_read(2'd0, 32'h5, "powerup_data");
        bus_read(2'd3, 32'h0, "powerup_edgecap");
        check32("powerup_irq", 32'(irq), 32'h0);

        in_port = 18'h0000D; idle(8);
        in_port = 18'h00005; idle(16);
        bus_read(2'd0, 32'h5, "glitch_data");
        bus_read(2'd3, 32'h0, "glitch_edgecap");

        in_port = 18'h0000D;
        bus_read(2'd1, 32'h5, "raw_cycle1");
        bus_read(2'd1, 32'h5, "raw_cycle2");
        bus_read(2'd1, 32'hD, "raw_cycle3");
        idle(16);
        bus_read(2'd0, 32'hD, "accept_data");
        bus_read(2'd3, 32'h8, "accept_edgecap");

        bus_write(2'd2, 32'h8);
        idle(1);
        check32("irq_set", 32'(irq), 32'(IRQ_EN));
        bus_read(2'd2, IRQ_EN ? 32'h8 : 32'h0, "irqmask_read");
        bus_write(2'd3, 32'h8);
        idle(1);
        check32("irq_clear", 32'(irq), 32'h0);
        bus_read(2'd3, 32'h0, "w1c_edgecap");
        in_port = 18'h00005; idle(16);
        bus_read(2'd3, 32'h8, "fall_edgecap");
        check32("fall_irq", 32'(irq), 32'(IRQ_EN));
        bus_read(2'd0, 32'h5, "fall_data");

        bus_write(2'd3, 32'h8);
        idle(1);
        in_port = 18'h0000D;
        wait_ticks(3, SC, 1'b0, "w1c_race");
        bus_write(2'd3, 32'h8);
        bus_read(2'd3, 32'h8, "set_wins_edgecap");
        bus_read(2'd0, 32'hD, "set_wins_data");

        in_port = 18'h00005;
        wait_ticks(3, 2, 1'b1, "mid_reset");
        reset = 1'b1; chipselect = 1'b1; write_n = 1'b1; address = 2'd3;
        @(posedge clk); #1;
        check32("midreset_readdata", readdata, 32'h0);
        check32("midreset_irq", 32'(irq), 32'h0);
        reset = 1'b0; chipselect = 1'b0;
        idle(6);
        bus_read(2'd0, 32'h5, "reprime_data");
        bus_read(2'd3, 32'h0, "reprime_edgecap");
        idle(16);
        bus_read(2'd3, 32'h0, "reprime_edgecap_late");
        check32("reprime_irq", 32'(irq), 32'h0);

        for (int n = 0; n < 4000; n++) begin
            case ($urandom % 16)
                0: in_port[$urandom_range(0, W - 1)] ^= 1'b1;
                1: in_port[$urandom_range(0, 2)]     ^= 1'b1;
                default: ;
            endcase
            chipselect = ($urandom % 2) == 0;
            write_n    = ($urandom % 4) != 0;
            address    = 2'($urandom % 4);
            writedata  = $urandom;
            reset      = (n >= 2000 && n < 2002);
            @(posedge clk); #1;
        end
        chipselect = 1'b0; write_n = 1'b1; reset = 1'b0;
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
